// File: rtl/instr_issue_queue.sv
// Instruction issue queue: FIFO feeding a processor data port, issued free-running (run) or one word per step edge.
// Latency: a pushed word is issuable one edge later; issue strobes the cycle after a pop. in_ready drops while full.
module instr_issue_queue #(
    parameter int INSTR_W = 20,
    parameter int DEPTH   = 8,
    parameter int PERIOD  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_data,
    output logic                       in_ready,
    input  logic                       run,
    input  logic                       step,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         data,
    output logic                       issue,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic [15:0]                issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(PERIOD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [GW-1:0]      gap_cnt;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               step_q;
    logic               step_pend;
    logic               step_rise;
    logic               enter_step;
    logic               gap_ok;
    logic               do_push;
    logic               do_pop;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign in_ready   = !full;
    assign step_rise  = step && !step_q;
    assign enter_step = (state == S_IDLE) && !run && step_rise;
    assign gap_ok     = (gap_cnt == '0);
    assign do_push    = in_valid && in_ready && !flush;
    // step_pend covers a step that arrives while the pacing gap is still running
    assign do_pop     = !flush && !empty && gap_ok &&
                        ((state == S_RUN) || enter_step || step_pend);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_RUN;
                end else if (step_rise) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (!step) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            data       <= '0;
            issue      <= 1'b0;
            issued_cnt <= '0;
            step_q     <= 1'b0;
            step_pend  <= 1'b0;
        end else begin
            step_q <= step;
            issue  <= do_pop;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                gap_cnt   <= '0;
                step_pend <= 1'b0;
            end else begin
                state <= state_nxt;
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    data       <= mem[rd_ptr];
                    issued_cnt <= issued_cnt + 16'd1;
                    gap_cnt    <= GAP_LOAD;
                    step_pend  <= 1'b0;
                end else begin
                    if (!gap_ok) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                    if (enter_step && !empty) begin
                        step_pend <= 1'b1;
                    end
                end
                if (do_push && !do_pop) begin
                    count <= count + 1'b1;
                end else if (do_pop && !do_push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Two queues (PERIOD 1 and 4) share one stimulus stream; each is scored against a queue-level model.
module tb_instr_issue_queue;
    localparam int W  = 20;
    localparam int D  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic run = 1'b0;
    logic step = 1'b0;
    logic flush = 1'b0;
    logic [W-1:0] in_data = '0;

    logic          in_ready   [2];
    logic          issue      [2];
    logic          empty      [2];
    logic          full       [2];
    logic [W-1:0]  data       [2];
    logic [CW-1:0] count      [2];
    logic [15:0]   issued_cnt [2];

    instr_issue_queue #(.INSTR_W(W), .DEPTH(D), .PERIOD(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .run(run), .step(step), .flush(flush),
        .data(data[0]), .issue(issue[0]), .count(count[0]),
        .empty(empty[0]), .full(full[0]), .issued_cnt(issued_cnt[0])
    );

    instr_issue_queue #(.INSTR_W(W), .DEPTH(D), .PERIOD(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .run(run), .step(step), .flush(flush),
        .data(data[1]), .issue(issue[1]), .count(count[1]),
        .empty(empty[1]), .full(full[1]), .issued_cnt(issued_cnt[1])
    );

    always #5 clk = ~clk;

    function automatic int per(int lane);
        return (lane == 0) ? 1 : 4;
    endfunction

    // Reference model: words held, mode (0 idle, 1 run, 2 step), cycle of last issue.
    logic [W-1:0] mq [2][$];
    logic [W-1:0] eq [2][$];
    int           mode     [2];
    bit           owed     [2];
    bit           exp_iss  [2];
    int           last     [2];
    logic [15:0]  m_issued [2];
    logic [W-1:0] m_data   [2];
    int           cyc;
    bit           step_prev;

    always @(posedge clk or negedge rst_n) begin
        int sz;
        bit es;
        bit pop;
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                mq[l].delete();
                eq[l].delete();
                mode[l]     = 0;
                owed[l]     = 1'b0;
                exp_iss[l]  = 1'b0;
                last[l]     = -100;
                m_issued[l] = '0;
                m_data[l]   = '0;
            end
            step_prev = 1'b0;
            cyc       = 0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                sz = mq[l].size();
                exp_iss[l] = 1'b0;
                if (flush) begin
                    mq[l].delete();
                    last[l] = -100;
                    owed[l] = 1'b0;
                end else begin
                    es  = (mode[l] == 0) && !run && step && !step_prev;
                    pop = (sz > 0) && ((cyc - last[l]) >= per(l)) &&
                          ((mode[l] == 1) || es || owed[l]);
                    if (pop) begin
                        m_data[l] = mq[l].pop_front();
                        eq[l].push_back(m_data[l]);
                        m_issued[l] = m_issued[l] + 16'd1;
                        last[l]    = cyc;
                        owed[l]    = 1'b0;
                        exp_iss[l] = 1'b1;
                    end else if (es && sz > 0) begin
                        owed[l] = 1'b1;
                    end
                    if (in_valid && sz < D) begin
                        mq[l].push_back(in_data);
                    end
                    if (mode[l] == 0) begin
                        mode[l] = run ? 1 : (es ? 2 : 0);
                    end else if (mode[l] == 1) begin
                        mode[l] = run ? 1 : 0;
                    end else begin
                        mode[l] = step ? 2 : 0;
                    end
                end
            end
            step_prev = step;
            cyc++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int lane, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d actual=%0h expected=%0h t=%0t", name, lane, act, exp, $time);
        end
    endtask

    // Monitor: runs mid-cycle, pops the scoreboard whenever an issue is due.
    always @(negedge clk) begin
        logic [W-1:0] w;
        for (int l = 0; l < 2; l++) begin
            chk("issue", l, 32'(issue[l]), 32'(exp_iss[l]));
            if (exp_iss[l] && eq[l].size() > 0) begin
                w = eq[l].pop_front();
                if (issue[l]) begin
                    chk("issue_data", l, 32'(data[l]), 32'(w));
                end
            end
            chk("data", l, 32'(data[l]), 32'(m_data[l]));
            chk("count", l, 32'(count[l]), 32'(mq[l].size()));
            chk("empty", l, 32'(empty[l]), 32'(mq[l].size() == 0));
            chk("full", l, 32'(full[l]), 32'(mq[l].size() == D));
            chk("in_ready", l, 32'(in_ready[l]), 32'(mq[l].size() != D));
            chk("issued_cnt", l, 32'(issued_cnt[l]), 32'(m_issued[l]));
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(logic [W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // fill, ninth word dropped
        for (int i = 1; i <= 9; i++) begin
            push(W'(i));
        end
        tick(2);

        // drain free-running
        run = 1'b1;
        tick(40);
        run = 1'b0;
        tick(3);

        // single-step
        push(20'hABCDE);
        push(20'h12345);
        tick(2);
        step = 1'b1; tick(5); step = 1'b0; tick(3);
        step = 1'b1; tick(1); step = 1'b0; tick(3);
        step = 1'b1; tick(1); step = 1'b0; tick(3);

        // flush with simultaneous push and run
        for (int i = 0; i < 8; i++) begin
            push(W'(32'h100 + i));
        end
        in_valid = 1'b1;
        in_data  = 20'h55555;
        run      = 1'b1;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick(6);
        run = 1'b0;
        tick(2);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            push(W'(32'h200 + i));
        end
        run = 1'b1;
        tick(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        run = 1'b0;
        tick(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run = !run;
            end
            step  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            tick(1);
        end
        in_valid = 1'b0;
        step     = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b1;
        run      = 1'b1;
        tick(40);
        run = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 The block SHALL provide parameter INSTR_W, default 20: instruction word width.
REQ-002 The block SHALL provide parameter DEPTH, default 8: queue entries, a power of two, at least 2.
REQ-003 The block SHALL provide parameter PERIOD, default 1: minimum clock cycles between consecutive issues, at least 1.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1: producer presents a word.
REQ-007 Port in_data, input, INSTR_W: word to enqueue.
REQ-008 Port in_ready, output, 1: queue can accept a word.
REQ-009 Port run, input, 1: level; free-running issue enabled.
REQ-010 Port step, input, 1: single-step request; acts on its rising edge.
REQ-011 Port flush, input, 1: synchronous queue clear.
REQ-012 Port data, output, INSTR_W: last issued word, held until the next issue; drives the processor data input.
REQ-013 Port issue, output, 1: one-cycle strobe marking a new word on data.
REQ-014 Port count, output, $clog2(DEPTH)+1: entries currently held.
REQ-015 Ports empty and full, outputs, 1 each: count==0 and count==DEPTH.
REQ-016 Port issued_cnt, output, 16: total words issued since reset.

Function
REQ-017 in_ready SHALL equal !full combinationally; a push SHALL occur on an edge where in_valid && in_ready && !flush.
REQ-018 The queue SHALL be FIFO-ordered, with read and write pointers wrapping modulo DEPTH.
REQ-019 Pop eligibility SHALL use the registered count: a word pushed at edge k SHALL be issuable no earlier than edge k+1.
REQ-020 The FSM SHALL have three states: IDLE, RUN and STEP.
REQ-021 IDLE SHALL go to RUN when run=1; otherwise to STEP on a step rising edge.
REQ-022 RUN SHALL go to IDLE when run=0.
REQ-023 STEP SHALL go to IDLE once step=0 is sampled.
REQ-024 In RUN, a pop SHALL occur on every edge where !empty && gap_cnt==0.
REQ-025 On entering STEP, exactly one pop SHALL occur if !empty; if empty, no pop SHALL occur, no issue SHALL be pending, and the FSM SHALL still pass through STEP.
REQ-026 A pop SHALL load data with the head word, drive issue=1 for exactly the following cycle, increment issued_cnt, and load gap_cnt with PERIOD-1.
REQ-027 gap_cnt SHALL decrement each cycle while nonzero, giving issues at most once every PERIOD cycles.
REQ-028 A simultaneous push and pop SHALL leave count unchanged.
REQ-029 While full, a push SHALL be blocked even on a cycle that pops.
REQ-030 flush=1 SHALL zero the pointers, count and gap_cnt, and SHALL suppress any push and pop on that edge.
REQ-031 On a flush edge, data, issued_cnt and FSM state SHALL hold, and issue SHALL be 0 the next cycle.
REQ-032 issued_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-033 step SHALL be ignored while in RUN; run rising while in STEP SHALL take effect only after STEP returns to IDLE.

Reset
REQ-034 rst_n=0 SHALL immediately force: FSM to IDLE; pointers, count, gap_cnt, data, issue and issued_cnt to 0; empty=1; full=0; in_ready=1.
REQ-035 Reset asserted mid-operation SHALL discard all queued words, and no issue pulse SHALL follow deassertion.
REQ-036 Queue storage contents need not be reset.

Verification
REQ-037 Fill test: DEPTH=8, run=0, push 0x00001..0x00008 -> full=1, in_ready=0, count=8; a ninth push of 0x00009 is dropped.
REQ-038 Run test: PERIOD=1, queue holds 0x00001..0x00008, raise run -> eight consecutive issue pulses in the order 0x00001..0x00008, then empty=1, issued_cnt=8, data holds 0x00008.
REQ-039 Pacing test: PERIOD=4, queue holds 3 words, run=1 -> issue pulses exactly 4 cycles apart.
REQ-040 Step test: queue holds 0xABCDE and 0x12345, run=0, step held high for 5 cycles -> exactly one issue with data=0xABCDE; a second step pulse issues 0x12345; a third step pulse gives no issue.
REQ-041 Flush/simultaneity test: full queue, run=1, flush and in_valid asserted together -> next cycle count=0, issue=0, data unchanged, in_ready=1.
REQ-042 Reset test: run=1 mid-stream, drop rst_n asynchronously between edges -> all outputs reach reset values before the next edge, and no issue pulse follows release.
